instr_seq_ctrl: RTL and testbench

INSTR_SEQ_CTRL -- requirements
Module: instr_seq_ctrl

---
 rtl/instr_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_instr_seq_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/mem/writeback with
// ack timeouts, illegal-opcode trap, halt, and a retired-instruction counter.
`timescale 1ns/1ps

// state   | meaning
// FETCH   | imem_req held until imem_ack or timeout
// DECODE  | classify opcode, latch instruction class
// EXECUTE | capture branch_taken, pick MEM or WB
// MEM     | dmem_req held until dmem_ack or timeout
// WB      | pc_en / rf_we strobe, retire
// HALT    | absorbing, halted=1
// FAULT   | absorbing, fault=1 with fault_code
module instr_seq_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ack,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic [1:0]  fault_code_nxt;
    logic        run;
    logic        is_load, is_store, is_branch, is_jal;
    logic        br_taken_q;
    logic        op_legal;

    assign op_legal = (opcode == OP_ALU)    || (opcode == OP_ALUI)  ||
                      (opcode == OP_LUI)    || (opcode == OP_AUIPC) ||
                      (opcode == OP_BRANCH) || (opcode == OP_JAL)   ||
                      (opcode == OP_LOAD)   || (opcode == OP_STORE);

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        fault_code_nxt = fault_code;
        case (state)
            S_FETCH: begin
                // run holds off the very first cycle after reset release
                if (run) begin
                    if (imem_ack) begin
                        state_nxt = S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_nxt      = S_FAULT;
                        fault_code_nxt = 2'b01;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 4'd1;
                    end
                end
            end
            S_DECODE: begin
                if (op_legal) begin
                    state_nxt = S_EXECUTE;
                end else if (opcode == OP_SYSTEM) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt      = S_FAULT;
                    fault_code_nxt = 2'b11;
                end
            end
            S_EXECUTE: begin
                wait_cnt_nxt = 4'd0;
                state_nxt    = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_nxt = S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt      = S_FAULT;
                    fault_code_nxt = 2'b10;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            S_WB: begin
                wait_cnt_nxt = 4'd0;
                state_nxt    = S_FETCH;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            wait_cnt   <= 4'd0;
            fault_code <= 2'b00;
            run        <= 1'b0;
            is_load    <= 1'b0;
            is_store   <= 1'b0;
            is_branch  <= 1'b0;
            is_jal     <= 1'b0;
            br_taken_q <= 1'b0;
            instret    <= 32'd0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            fault_code <= fault_code_nxt;
            run        <= 1'b1;
            if (state == S_DECODE) begin
                is_load   <= (opcode == OP_LOAD);
                is_store  <= (opcode == OP_STORE);
                is_branch <= (opcode == OP_BRANCH);
                is_jal    <= (opcode == OP_JAL);
            end
            if (state == S_EXECUTE) begin
                br_taken_q <= branch_taken;
            end
            if (state == S_WB) begin
                instret <= instret + 32'd1;
            end
        end
    end

    assign imem_req = (state == S_FETCH) && run;
    assign dmem_req = (state == S_MEM);
    assign dmem_we  = (state == S_MEM) && is_store;
    assign pc_en    = (state == S_WB);
    assign rf_we    = (state == S_WB) && !is_store && !is_branch;
    assign pc_sel   = (state == S_WB) && (is_jal || (is_branch && br_taken_q));
    assign halted   = (state == S_HALT);
    assign fault    = (state == S_FAULT);

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Bench for instr_seq_ctrl: an instruction-level model builds the expected
// per-cycle output timeline; a compare process checks the DUT every cycle.
`timescale 1ns/1ps

module tb_instr_seq_ctrl;
    localparam int TIMEOUT = 15;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        branch_taken = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        imem_req, dmem_req, dmem_we, rf_we, pc_en, pc_sel, halted, fault;
    logic [1:0]  fault_code;
    logic [31:0] instret;

    instr_seq_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .imem_ack(imem_ack), .opcode(opcode),
        .branch_taken(branch_taken), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_en(pc_en), .pc_sel(pc_sel), .halted(halted),
        .fault(fault), .fault_code(fault_code), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        imem_req, dmem_req, dmem_we, rf_we, pc_en, pc_sel, halted, fault;
        logic [1:0]  fault_code;
        logic [31:0] instret;
    } rec_t;

    rec_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          m_halted, m_fault;
    logic [1:0]  m_code;
    logic [31:0] m_instret;

    function automatic rec_t mk(bit ir, bit dr, bit dw, bit rw, bit pe, bit ps);
        rec_t r;
        r.imem_req = ir; r.dmem_req = dr; r.dmem_we = dw;
        r.rf_we = rw; r.pc_en = pe; r.pc_sel = ps;
        r.halted = m_halted; r.fault = m_fault;
        r.fault_code = m_code; r.instret = m_instret;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // every cycle that has a queued expectation is compared at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            rec_t e, a;
            e = exp_q.pop_front();
            a = {imem_req, dmem_req, dmem_we, rf_we, pc_en, pc_sel, halted, fault,
                 fault_code, instret};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h", cyc, a, e);
            end
        end
    end

    task automatic step(logic ia, logic da, logic bt, rec_t r);
        @(posedge clk);
        #1;
        imem_ack = ia; dmem_ack = da; branch_taken = bt;
        cyc++;
        exp_q.push_back(r);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
        exp_q.delete();
        m_halted = 0; m_fault = 0; m_code = 2'b00; m_instret = 32'd0;
        #1;
        check("reset_outputs",
              {imem_req, dmem_req, dmem_we, rf_we, pc_en, pc_sel, halted, fault,
               fault_code, instret}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1, 1, 1, mk(0, 0, 0, 0, 0, 0));
    endtask

    // iw/dw: wait cycles before imem/dmem ack; >= TIMEOUT means never acked
    task automatic exec_instr(logic [6:0] op, int iw, int dw, bit bt, bit abort_mem);
        bit ld, st, br, jl, legal;
        ld = (op == OP_LOAD); st = (op == OP_STORE);
        br = (op == OP_BRANCH); jl = (op == OP_JAL);
        legal = ld || st || br || jl || (op == OP_ALU) || (op == OP_ALUI) ||
                (op == OP_LUI) || (op == OP_AUIPC);
        opcode = op;
        for (int k = 0; k <= iw && k < TIMEOUT; k++)
            step(k == iw, 1, 0, mk(1, 0, 0, 0, 0, 0));
        if (iw >= TIMEOUT) begin m_fault = 1; m_code = 2'b01; return; end
        step(1, 1, 0, mk(0, 0, 0, 0, 0, 0));
        if (op == OP_SYSTEM) begin m_halted = 1; return; end
        if (!legal) begin m_fault = 1; m_code = 2'b11; return; end
        step(1, 1, bt, mk(0, 0, 0, 0, 0, 0));
        if (ld || st) begin
            for (int k = 0; k <= dw && k < TIMEOUT; k++) begin
                step(1, k == dw, 0, mk(0, 1, st, 0, 0, 0));
                if (abort_mem && k == 1) return;
            end
            if (dw >= TIMEOUT) begin m_fault = 1; m_code = 2'b10; return; end
        end
        step(0, 0, 0, mk(0, 0, 0, !(st || br), 1, jl || (br && bt)));
        m_instret++;
    endtask

    initial begin
        #2;
        do_reset();

        exec_instr(OP_ALU, 0, 0, 0, 0);
        check("alu_wb_cycle", 64'(cyc), 64'd4);
        check("alu_wb_strobes", {61'd0, pc_en, rf_we, pc_sel}, {61'd0, 3'b110});
        exec_instr(OP_BRANCH, 0, 0, 1, 0);
        check("br_taken_wb", {61'd0, pc_en, pc_sel, rf_we}, {61'd0, 3'b110});
        check("alu_instret", 64'(instret), 64'd1);
        exec_instr(OP_BRANCH, 1, 0, 0, 0);
        check("br_not_taken_pc_sel", {63'd0, pc_sel}, 64'd0);
        exec_instr(OP_STORE, 0, 3, 1, 0);
        check("store_wb_rf_we", {62'd0, pc_en, rf_we}, {62'd0, 2'b10});
        exec_instr(OP_JAL, 2, 0, 0, 0);
        exec_instr(OP_LOAD, 0, 0, 0, 0);
        exec_instr(OP_LUI, 14, 0, 0, 0);
        exec_instr(OP_AUIPC, 0, 0, 0, 0);
        exec_instr(OP_ALUI, 0, 0, 0, 0);
        check("mixed_instret", 64'(instret), 64'd8);

        exec_instr(OP_ALU, TIMEOUT, 0, 0, 0);
        idle(4);
        check("imem_timeout", {60'd0, fault, fault_code, imem_req}, {60'd0, 4'b1010});
        do_reset();

        exec_instr(OP_LOAD, 0, TIMEOUT, 0, 0);
        idle(3);
        check("dmem_timeout_code", {62'd0, fault_code}, 64'd2);
        do_reset();

        exec_instr(7'b0000000, 0, 0, 0, 0);
        idle(3);
        check("illegal_code", {62'd0, fault_code}, 64'd3);
        do_reset();

        exec_instr(OP_ALU, 0, 0, 0, 0);
        exec_instr(OP_SYSTEM, 1, 0, 0, 0);
        idle(4);
        check("halt_state", {63'd0, halted}, 64'd1);
        check("halt_instret", 64'(instret), 64'd1);
        do_reset();

        exec_instr(OP_ALU, 0, 0, 0, 0);
        exec_instr(OP_ALUI, 1, 0, 0, 0);
        exec_instr(OP_LUI, 0, 0, 0, 0);
        exec_instr(OP_AUIPC, 0, 0, 0, 0);
        exec_instr(OP_BRANCH, 0, 0, 1, 0);
        exec_instr(OP_JAL, 0, 0, 0, 0);
        exec_instr(OP_LOAD, 0, 2, 0, 0);
        exec_instr(OP_STORE, 0, 10, 0, 1);
        check("pre_abort_instret", 64'(instret), 64'd7);
        check("pre_abort_dmem", {62'd0, dmem_req, dmem_we}, {62'd0, 2'b11});
        @(negedge clk);
        #1;
        do_reset();
        exec_instr(OP_ALU, 2, 0, 0, 0);
        check("resume_wb", {62'd0, pc_en, rf_we}, {62'd0, 2'b11});
        check("resume_instret", 64'(instret), 64'd0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
